// File: rtl/lcd_pkg.sv
// Shared constants and types for the LCD bus capture path: character codes,
// command encodings and the capture FSM state.
package lcd_pkg;

  localparam int         DEFAULT_WIDTH     = 16;
  localparam logic [7:0] CHAR_ZERO_DEFAULT = 8'h30;
  localparam logic [7:0] CHAR_ONE_DEFAULT  = 8'h31;

  localparam logic [7:0] CMD_CLEAR         = 8'h01;
  localparam logic [7:0] CMD_SET_ADDR      = 8'h80;
  localparam logic [7:0] CMD_SET_ADDR_MASK = 8'h80;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } cap_state_e;

  // Set-address commands carry the target position in the bits below the opcode flag.
  function automatic logic is_set_addr(input logic [7:0] code);
    return (code & CMD_SET_ADDR_MASK) == CMD_SET_ADDR;
  endfunction

  function automatic logic [7:0] set_addr_field(input logic [7:0] code);
    return code & ~CMD_SET_ADDR_MASK;
  endfunction

endpackage

// File: rtl/lcd_strobe_detect.sv
// Samples the LCD bus while enable is high and flags the falling edge of enable,
// presenting the byte that was on the bus just before the edge.
module lcd_strobe_detect (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] lcd_data,
  input  logic       lcd_enable,
  input  logic       lcd_rs,
  output logic       strobe,
  output logic [7:0] byte_data,
  output logic       byte_rs
);

  logic       en_q_reg;
  logic [7:0] data_q_reg;
  logic       rs_q_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      en_q_reg   <= 1'b0;
      data_q_reg <= 8'h00;
      rs_q_reg   <= 1'b0;
    end else begin
      en_q_reg <= lcd_enable;
      // Bus contents are only meaningful while enable is high.
      if (lcd_enable) begin
        data_q_reg <= lcd_data;
        rs_q_reg   <= lcd_rs;
      end
    end
  end

  assign strobe    = en_q_reg & ~lcd_enable;
  assign byte_data = data_q_reg;
  assign byte_rs   = rs_q_reg;

endmodule

// File: rtl/lcd_binary_capture.sv
// Snoops the LCD bus and rebuilds a displayed string of '0'/'1' characters into a
// binary word, flagging characters that are neither.
module lcd_binary_capture
  import lcd_pkg::*;
#(
  parameter int         WIDTH     = DEFAULT_WIDTH,
  parameter logic [7:0] CHAR_ZERO = CHAR_ZERO_DEFAULT,
  parameter logic [7:0] CHAR_ONE  = CHAR_ONE_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [7:0]               lcd_data,
  input  logic                     lcd_enable,
  input  logic                     lcd_rs,
  output logic [WIDTH-1:0]         binary_output,
  output logic                     word_valid,
  output logic                     word_err,
  output logic                     char_error,
  output logic [$clog2(WIDTH)-1:0] char_pos
);

  localparam int              POS_W    = $clog2(WIDTH);
  localparam logic [POS_W-1:0] LAST_POS = POS_W'(WIDTH - 1);

  logic       strobe;
  logic [7:0] byte_data;
  logic       byte_rs;

  lcd_strobe_detect u_strobe_detect (
    .clk        (clk),
    .rst_n      (rst_n),
    .lcd_data   (lcd_data),
    .lcd_enable (lcd_enable),
    .lcd_rs     (lcd_rs),
    .strobe     (strobe),
    .byte_data  (byte_data),
    .byte_rs    (byte_rs)
  );

  cap_state_e       state_reg, state_next;
  logic [POS_W-1:0] pos_reg, pos_next;
  logic [WIDTH-1:0] asm_reg, asm_next;
  logic             sticky_reg, sticky_next;
  logic [WIDTH-1:0] binary_output_reg;
  logic             word_valid_reg, word_err_reg, char_error_reg;

  // Byte decode
  logic       is_cmd, is_char;
  logic       cmd_clear, cmd_set_addr;
  logic [7:0] addr_field;
  logic       char_zero, char_one, char_write, char_bad;
  logic       word_done;
  logic       err_base, err_accum;

  assign is_cmd       = strobe & ~byte_rs;
  assign is_char      = strobe & byte_rs;
  assign addr_field   = set_addr_field(byte_data);
  assign cmd_clear    = is_cmd && (byte_data == CMD_CLEAR);
  assign cmd_set_addr = is_cmd && is_set_addr(byte_data) && (32'(addr_field) < WIDTH);

  assign char_zero  = is_char && (byte_data == CHAR_ZERO);
  assign char_one   = is_char && (byte_data == CHAR_ONE);
  assign char_write = char_zero | char_one;
  assign char_bad   = is_char & ~char_write;
  assign word_done  = is_char && (pos_reg == LAST_POS);
  assign err_accum  = err_base | char_bad;

  // Display position p maps to bit WIDTH-1-p so the leftmost character is the MSB.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_asm_bit
    localparam logic [POS_W-1:0] BIT_POS = POS_W'(WIDTH - 1 - gi);
    assign asm_next[gi] = cmd_clear                          ? 1'b0 :
                          (char_write && pos_reg == BIT_POS) ? char_one :
                                                               asm_reg[gi];
  end

  always_comb begin
    pos_next = pos_reg;
    if (cmd_clear) begin
      pos_next = '0;
    end else if (cmd_set_addr) begin
      pos_next = POS_W'(addr_field);
    end else if (is_char) begin
      pos_next = (pos_reg == LAST_POS) ? '0 : pos_reg + POS_W'(1);
    end
  end

  always_comb begin
    sticky_next = sticky_reg;
    if (cmd_clear || word_done) begin
      sticky_next = 1'b0;
    end else if (is_char) begin
      sticky_next = err_accum;
    end
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM: next state
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (word_done) begin
          state_next = IDLE;
        end else if (cmd_set_addr || is_char) begin
          state_next = COLLECT;
        end
      end
      COLLECT: begin
        if (word_done || cmd_clear) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM: outputs -- an idle capture starts a fresh word, so no error history carries in.
  always_comb begin
    err_base = 1'b0;
    case (state_reg)
      IDLE:    err_base = 1'b0;
      COLLECT: err_base = sticky_reg;
      default: err_base = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pos_reg           <= '0;
      asm_reg           <= '0;
      sticky_reg        <= 1'b0;
      binary_output_reg <= '0;
      word_valid_reg    <= 1'b0;
      word_err_reg      <= 1'b0;
      char_error_reg    <= 1'b0;
    end else begin
      pos_reg        <= pos_next;
      asm_reg        <= asm_next;
      sticky_reg     <= sticky_next;
      word_valid_reg <= word_done;
      char_error_reg <= char_bad;
      // Published word includes the final character written in this same cycle.
      if (word_done) begin
        binary_output_reg <= asm_next;
        word_err_reg      <= err_accum;
      end
    end
  end

  assign binary_output = binary_output_reg;
  assign word_valid    = word_valid_reg;
  assign word_err      = word_err_reg;
  assign char_error    = char_error_reg;
  assign char_pos      = pos_reg;

endmodule

// File: tb/tb_lcd_binary_capture.sv
// Directed and randomized bus traffic against a character-level model of the display.
module tb_lcd_binary_capture;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  lcd_data = 8'h00;
  logic        lcd_enable = 1'b0;
  logic        lcd_rs = 1'b0;
  logic [15:0] binary_output;
  logic        word_valid;
  logic        word_err;
  logic        char_error;
  logic [3:0]  char_pos;

  int n_checks = 0;
  int n_fail   = 0;

  lcd_binary_capture dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .lcd_data      (lcd_data),
    .lcd_enable    (lcd_enable),
    .lcd_rs        (lcd_rs),
    .binary_output (binary_output),
    .word_valid    (word_valid),
    .word_err      (word_err),
    .char_error    (char_error),
    .char_pos      (char_pos)
  );

  always #5 clk = ~clk;

  // Model: what the display shows, one entry per character cell.
  bit          m_cell[16];
  int          m_pos;
  bit          m_err;
  logic [15:0] m_out;
  int          m_words;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] display_word();
    logic [15:0] w;
    for (int i = 0; i < 16; i++) w[15-i] = m_cell[i];
    return w;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_cell[i] = 1'b0;
    m_pos = 0;
    m_err = 1'b0;
    m_out = 16'h0000;
  endtask

  task automatic model_byte(input bit rs, input logic [7:0] d, output bit exp_valid,
                            output bit exp_cerr, output bit exp_werr);
    exp_valid = 1'b0;
    exp_cerr  = 1'b0;
    exp_werr  = 1'b0;
    if (!rs) begin
      if (d == 8'h01) begin
        for (int i = 0; i < 16; i++) m_cell[i] = 1'b0;
        m_pos = 0;
        m_err = 1'b0;
      end else if (d >= 8'h80 && (int'(d) - 128) < 16) begin
        m_pos = int'(d) - 128;
      end
    end else begin
      if (d == 8'h30)      m_cell[m_pos] = 1'b0;
      else if (d == 8'h31) m_cell[m_pos] = 1'b1;
      else begin
        exp_cerr = 1'b1;
        m_err    = 1'b1;
      end
      if (m_pos == 15) begin
        exp_valid = 1'b1;
        exp_werr  = m_err;
        m_out     = display_word();
        m_err     = 1'b0;
        m_pos     = 0;
        m_words++;
      end else begin
        m_pos++;
      end
    end
  endtask

  task automatic send_byte(input bit rs, input logic [7:0] d, input int hi, input int lo);
    bit ev, ec, ew;
    lcd_enable = 1'b1;
    lcd_data   = d;
    lcd_rs     = rs;
    repeat (hi) tick();
    lcd_enable = 1'b0;
    lcd_data   = 8'($urandom);
    lcd_rs     = 1'($urandom);
    model_byte(rs, d, ev, ec, ew);
    tick();
    check("word_valid", 32'(word_valid), 32'(ev));
    check("char_error", 32'(char_error), 32'(ec));
    check("char_pos", 32'(char_pos), 32'(m_pos));
    check("binary_output", 32'(binary_output), 32'(m_out));
    if (ev) check("word_err", 32'(word_err), 32'(ew));
    for (int i = 1; i < lo; i++) begin
      tick();
      check("word_valid_pulse", 32'(word_valid), 32'd0);
      check("char_error_pulse", 32'(char_error), 32'd0);
    end
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(1'b1, s[i], 2, 2);
  endtask

  task automatic do_reset();
    lcd_enable = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    model_reset();
    check("rst_binary_output", 32'(binary_output), 32'd0);
    check("rst_word_valid", 32'(word_valid), 32'd0);
    check("rst_word_err", 32'(word_err), 32'd0);
    check("rst_char_error", 32'(char_error), 32'd0);
    check("rst_char_pos", 32'(char_pos), 32'd0);
  endtask

  initial begin
    int words_before;
    bit rs;
    logic [7:0] d;

    m_words = 0;
    model_reset();

    // 1: alternating word
    do_reset();
    send_str("1010101010101010");
    check("t1_word", 32'(binary_output), 32'h0000AAAA);

    // 2: enable stuck high, then stuck low
    lcd_enable = 1'b1;
    lcd_rs = 1'b1;
    for (int i = 0; i < 200; i++) begin
      lcd_data = (i % 2 == 0) ? 8'h31 : 8'($urandom);
      tick();
      check("t2_word_valid", 32'(word_valid), 32'd0);
      check("t2_char_error", 32'(char_error), 32'd0);
    end
    check("t2_char_pos", 32'(char_pos), 32'd0);
    send_byte(1'b0, 8'h00, 1, 2);
    for (int i = 0; i < 50; i++) begin
      lcd_data = 8'($urandom);
      lcd_rs = 1'($urandom);
      tick();
      check("t2_low_word_valid", 32'(word_valid), 32'd0);
      check("t2_low_char_error", 32'(char_error), 32'd0);
    end

    // 3: one bad character, then a clean word
    send_str("000X000000000000");
    check("t3_word", 32'(binary_output), 32'h00000000);
    send_str("1111111111111111");
    check("t3_clean_word", 32'(binary_output), 32'h0000FFFF);

    // 4: clear mid-word
    words_before = m_words;
    send_str("11111");
    send_byte(1'b0, 8'h01, 2, 2);
    send_str("0000000000000000");
    check("t4_word_count", 32'(m_words - words_before), 32'd1);
    check("t4_word", 32'(binary_output), 32'h00000000);

    // 5: set-address, out-of-range address
    do_reset();
    send_byte(1'b0, 8'h8C, 2, 2);
    send_str("1111");
    check("t5_word", 32'(binary_output), 32'h0000000F);
    send_byte(1'b0, 8'h83, 2, 2);
    send_byte(1'b0, 8'h95, 2, 2);
    check("t5_ignored_pos", 32'(char_pos), 32'd3);
    send_byte(1'b0, 8'h01, 2, 2);

    // 6: reset landing on a strobe
    send_str("1101101");
    lcd_enable = 1'b1;
    lcd_data = 8'h31;
    lcd_rs = 1'b1;
    tick();
    tick();
    lcd_enable = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    model_reset();
    check("t6_binary_output", 32'(binary_output), 32'd0);
    check("t6_word_valid", 32'(word_valid), 32'd0);
    check("t6_word_err", 32'(word_err), 32'd0);
    check("t6_char_error", 32'(char_error), 32'd0);
    check("t6_char_pos", 32'(char_pos), 32'd0);
    tick();
    check("t6_dropped_pos", 32'(char_pos), 32'd0);
    check("t6_dropped_cerr", 32'(char_error), 32'd0);
    send_str("1111000011110000");
    check("t6_word", 32'(binary_output), 32'h0000F0F0);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 9) < 8) begin
        rs = 1'b1;
        if ($urandom_range(0, 9) == 0) d = 8'($urandom);
        else d = $urandom_range(0, 1) ? 8'h31 : 8'h30;
      end else begin
        rs = 1'b0;
        case ($urandom_range(0, 3))
          0:       d = 8'h01;
          1, 2:    d = 8'h80 | 8'($urandom_range(0, 20));
          default: d = 8'($urandom);
        endcase
      end
      send_byte(rs, d, $urandom_range(1, 3), $urandom_range(1, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
